uart_tx_core: RTL and testbench

//  Byte-stream UART transmitter for the SoC peripheral bus: buffers bytes in a small FIFO
//  and serialises them 8N1 (or 8N2) onto the pad line peripheral_uart_tx_o.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_core.sv | 152 +++++++++++++++
 tb/tb_uart_tx_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, constants and divisor helper for the UART transmitter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // Clock cycles per bit, truncated towards zero.
  function automatic int calc_baud_div(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead FIFO; occupancy is tracked by a count register
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the count, so a wrapped pointer pair is never ambiguous.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - FIFO-buffered 8N1/8N2 UART transmitter with registered serial output
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [7:0]                        tx_data_i,
  input  logic                              tx_valid_i,
  output logic                              tx_ready_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
  output logic                              busy_o,
  output logic                              tx_o
);

  localparam int DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $error("uart_tx_core: baud divisor %0d must be at least 2", DIV);
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
    $error("uart_tx_core: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("uart_tx_core: FIFO_DEPTH=%0d must be a power of two >= 2", FIFO_DEPTH);
  end

  uart_tx_state_e            state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [BW-1:0]             baud_cnt;
  logic [2:0]                bit_cnt;
  logic                      tx_q;
  logic                      busy_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       baud_end;
  logic       stop_end;

  assign tx_ready_o = !fifo_full;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign stop_end = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
  // Pop from IDLE, or at the very end of the stop period so the next start bit follows with no gap.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || stop_end);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (reset_i),
    .push  (tx_valid_i),
    .wdata (tx_data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            shift    <= fifo_rdata;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_q     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              tx_q    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_q    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (fifo_pop) begin
                shift <= fifo_rdata;
                tx_q  <= 1'b0;
                state <= START;
              end else begin
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - randomized scoreboard bench for uart_tx_core (DIV=4, two stop bits)
`timescale 1ns/1ps
module tb_uart_tx_core;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int DEPTH  = 16;
  localparam int NSTOP  = 2;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = (1 + 8 + NSTOP) * DIV;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start = -1;
  byte unsigned exp_q[$];
  int starts_q[$];

  uart_tx_core #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH),
    .STOP_BITS   (NSTOP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .fifo_count_o (fifo_count),
    .busy_o       (busy),
    .tx_o         (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
    check(i < budget, name, i, budget);
    @(posedge clk); #1;
  endtask

  // Line receiver: expects each frame as start(0), 8 data LSB first, NSTOP ones, DIV cycles each.
  initial begin : monitor
    logic [10:0] bits;
    logic [7:0]  rx;
    byte unsigned exp_b;
    bit   had_exp;
    bit   aborted;
    int   errs;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        last_start = cyc;
        starts_q.push_back(cyc);
        had_exp = (exp_q.size() != 0);
        exp_b   = had_exp ? exp_q.pop_front() : 8'h00;
        bits    = {2'b11, exp_b, 1'b0};
        rx      = 8'h00;
        errs    = 0;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (tx !== bits[k / DIV]) errs++;
          if ((k % DIV) == DIV / 2 && (k / DIV) >= 1 && (k / DIV) <= 8) rx[k / DIV - 1] = tx;
        end
        if (!aborted) begin
          if (!had_exp) check(1'b0, "unexpected_frame", rx, -1);
          else begin
            check(rx == exp_b, "rx_byte", rx, exp_b);
            check(errs == 0, "frame_bit_timing_errors", errs, 0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    byte unsigned b[20];
    byte unsigned v;
    int push_cyc, fall_cyc, acc, first_drop, bad, w, seen, starts_before, base;
    bit rdy;

    #2 rst = 1'b1;
    #1;
    check(tx === 1'b1, "reset_tx", tx, 1);
    check(busy === 1'b0, "reset_busy", busy, 0);
    check(tx_ready === 1'b1, "reset_ready", tx_ready, 1);
    check(fifo_count === '0, "reset_count", fifo_count, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Single bytes from idle: start latency, frame shape and busy duration.
    foreach (b[i]) b[i] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      v = (t == 0) ? 8'h55 : 8'hA3;
      tx_data = v; tx_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      push_cyc = cyc;
      tx_valid = 1'b0;
      check(fifo_count == 1, "count_after_single_push", fifo_count, 1);
      seen = 0; fall_cyc = -1;
      for (int i = 0; i < FRAME + 20; i++) begin
        @(negedge clk);
        if (busy === 1'b1) seen = 1;
        else if (seen) begin fall_cyc = cyc; break; end
      end
      check(last_start == push_cyc + 1, "start_latency", last_start - push_cyc, 1);
      check(fall_cyc == last_start + FRAME, "busy_length", fall_cyc - last_start, FRAME);
      @(posedge clk); #1;
    end

    // Burst: valid held with 20 distinct bytes from empty.
    base = $urandom;
    for (int i = 0; i < 20; i++) b[i] = 8'(base + i * 37);
    starts_q.delete();
    acc = 0; first_drop = -1;
    tx_valid = 1'b1; tx_data = b[0];
    for (int c = 0; c < 4000 && acc < 20; c++) begin
      rdy = tx_ready;
      if (rdy) exp_q.push_back(b[acc]);
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        if (acc < 20) tx_data = b[acc];
      end
      if (c == 0) check(fifo_count == 1, "count_first_push", fifo_count, 1);
      if (c == 1) check(fifo_count == 1, "count_push_pop_at_one", fifo_count, 1);
      if (tx_ready !== 1'b1 && first_drop < 0) begin
        first_drop = acc;
        check(acc == DEPTH + 1, "accepted_before_full", acc, DEPTH + 1);
        check(fifo_count == DEPTH, "count_full", fifo_count, DEPTH);
      end
    end
    tx_valid = 1'b0;
    check(acc == 20, "burst_accepted", acc, 20);
    wait_drain(21 * FRAME + 100, "burst_drain");
    check(starts_q.size() == 20, "burst_frames", starts_q.size(), 20);
    bad = 0;
    for (int i = 1; i < starts_q.size(); i++)
      if (starts_q[i] - starts_q[i-1] != FRAME) bad++;
    check(bad == 0, "back_to_back_gaps", bad, 0);

    // Random bytes with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 50)) begin @(posedge clk); #1; end
      v = 8'($urandom);
      tx_data = v; tx_valid = 1'b1;
      for (w = 0; w < 400 && tx_ready !== 1'b1; w++) begin @(posedge clk); #1; end
      check(w < 400, "random_push_wait", w, 400);
      exp_q.push_back(v);
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
    wait_drain(32 * FRAME + 100, "random_drain");

    // Reset in the middle of data bit 4 with bytes still queued.
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      tx_data = v; tx_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    check(fifo_count == 4, "count_before_reset", fifo_count, 4);
    for (w = 0; w < 200 && cyc != last_start + 5 * DIV + 1; w++) @(negedge clk);
    check(w < 200, "reach_data_bit4", w, 200);
    #2 rst = 1'b1;
    #1;
    check(tx === 1'b1, "midframe_reset_tx", tx, 1);
    check(busy === 1'b0, "midframe_reset_busy", busy, 0);
    check(fifo_count === '0, "midframe_reset_count", fifo_count, 0);
    check(tx_ready === 1'b1, "midframe_reset_ready", tx_ready, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    starts_before = starts_q.size();
    repeat (200) @(negedge clk);
    check(starts_q.size() == starts_before, "no_frame_after_reset", starts_q.size() - starts_before, 0);
    check(tx === 1'b1 && busy === 1'b0, "idle_after_reset", {busy, tx}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
